wf_iq_boxcar_decim: RTL and testbench

//  Boxcar-average decimator on the waterfall IQ path, directly upstream of the 8K x 32b WF sampler.

---
 rtl/wf_iq_boxcar_decim.sv | 211 +++++++++++++++++++++
 tb/tb_wf_iq_boxcar_decim.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wf_iq_boxcar_decim.sv
// -----------------------------------------------------------------------------
// wf_iq_boxcar_decim
//
// Boxcar-average decimator for the waterfall IQ path. It sums 2^k consecutive
// signed IQ samples, then rounds (half toward +inf), scales by 2^(k+IN_W-OUT_W)
// and saturates the result to OUT_W bits. The output strobe/data drive the
// waterfall sampler write port directly, in the same clock domain.
//
// Pipeline:
//   stage 1 : frame accumulator; the last sample's sum is captured into stage 2
//   stage 2 : round / shift / clamp, registered onto out_stb/out_i/out_q
//   out_stb is high on the 2nd clock after the clock that sampled the frame's
//   last in_stb.
//
// Ports:
//   adc_clk     single clock for all logic
//   rst_n       asynchronous active-low reset
//   decim_log2  average 2^decim_log2 samples; latched at frame start
//   restart     abandon the current frame (and any undelivered result)
//   in_stb      input sample valid (any duty cycle up to every clock)
//   in_i, in_q  input samples, signed IN_W
//   out_stb     one-cycle pulse: out_i/out_q updated
//   out_i/out_q averaged samples, signed OUT_W, held between strobes
//   sat         sticky flag: some output was clamped since the last sat_clr
//   sat_clr     clear sat; a saturation in the same cycle wins
// -----------------------------------------------------------------------------
module wf_iq_boxcar_decim #(
    parameter int IN_W     = 24,
    parameter int OUT_W    = 16,
    parameter int MAX_LOG2 = 7
) (
    input  logic             adc_clk,
    input  logic             rst_n,
    input  logic [2:0]       decim_log2,
    input  logic             restart,
    input  logic             in_stb,
    input  logic [IN_W-1:0]  in_i,
    input  logic [IN_W-1:0]  in_q,
    output logic             out_stb,
    output logic [OUT_W-1:0] out_i,
    output logic [OUT_W-1:0] out_q,
    output logic             sat,
    input  logic             sat_clr
);

    localparam int ACC_W = IN_W + MAX_LOG2 + 1;   // no wrap for any k <= MAX_LOG2
    localparam int CNT_W = MAX_LOG2 + 1;
    localparam int K_W   = 3;
    localparam int SH_W  = 6;

    localparam logic signed [ACC_W-1:0] OUT_MAX = (ACC_W'(1) <<< (OUT_W - 1)) - ACC_W'(1);
    localparam logic signed [ACC_W-1:0] OUT_MIN = ~OUT_MAX;

    // -------------------------------------------------------------------------
    // Shared frame control
    // -------------------------------------------------------------------------
    logic [CNT_W-1:0] count_reg;
    logic [K_W-1:0]   k_reg;
    logic             s2_valid_reg;
    logic [K_W-1:0]   s2_k_reg;
    logic             out_stb_reg;
    logic             sat_reg;

    logic [K_W-1:0]   decim_eff;
    logic [K_W-1:0]   k_cur;
    logic [CNT_W-1:0] last_idx;
    logic             frame_start;
    logic             frame_done;
    logic             out_fire;
    logic [SH_W-1:0]  sh;
    logic [1:0]       clip_vec;

    logic [IN_W-1:0]  in_data [2];
    logic [OUT_W-1:0] out_val [2];

    assign in_data[0] = in_i;
    assign in_data[1] = in_q;

    // Out-of-range requests fall back to the deepest supported average.
    generate
        if (MAX_LOG2 < (1 << K_W) - 1) begin : g_k_clamp
            assign decim_eff = (decim_log2 > K_W'(MAX_LOG2)) ? K_W'(MAX_LOG2) : decim_log2;
        end else begin : g_k_pass
            assign decim_eff = decim_log2;
        end
    endgenerate

    // Index of the last sample in the frame currently being accumulated.
    assign last_idx = (CNT_W'(1) << k_reg) - CNT_W'(1);

    always_comb begin
        // A restart turns the current cycle into an idle one, so a coincident
        // sample opens the new frame with this cycle's decim_log2.
        frame_start = in_stb && (restart || (count_reg == '0));
        k_cur       = frame_start ? decim_eff : k_reg;
        frame_done  = in_stb && (frame_start ? (decim_eff == '0) : (count_reg == last_idx));
        // restart also drops a finished sum that has not reached out_stb yet.
        out_fire    = s2_valid_reg && !restart;
    end

    assign sh = SH_W'(s2_k_reg) + SH_W'(IN_W - OUT_W);

    always_ff @(posedge adc_clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg    <= '0;
            k_reg        <= '0;
            s2_valid_reg <= 1'b0;
            s2_k_reg     <= '0;
            out_stb_reg  <= 1'b0;
            sat_reg      <= 1'b0;
        end else begin
            if (in_stb) begin
                if (frame_done) begin
                    count_reg <= '0;
                end else if (frame_start) begin
                    count_reg <= CNT_W'(1);
                end else begin
                    count_reg <= count_reg + CNT_W'(1);
                end
            end else if (restart) begin
                count_reg <= '0;
            end

            if (frame_start) begin
                k_reg <= decim_eff;
            end

            s2_valid_reg <= frame_done;
            if (frame_done) begin
                s2_k_reg <= k_cur;
            end

            out_stb_reg <= out_fire;

            if (out_fire && (|clip_vec)) begin
                sat_reg <= 1'b1;
            end else if (sat_clr) begin
                sat_reg <= 1'b0;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Per-channel datapath (0 = I, 1 = Q), identical for both channels
    // -------------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_ch
            logic signed [ACC_W-1:0] sample;
            logic signed [ACC_W-1:0] acc_reg;
            logic signed [ACC_W-1:0] s2_sum_reg;
            logic signed [ACC_W-1:0] rnd_const;
            logic signed [ACC_W-1:0] sum_rnd;
            logic signed [ACC_W-1:0] shifted;
            logic        [OUT_W-1:0] clamped;
            logic        [OUT_W-1:0] out_reg;
            logic                    clip;

            assign sample = {{(ACC_W - IN_W){in_data[gi][IN_W-1]}}, in_data[gi]};

            // Round half toward +inf: add half an output LSB, then floor-shift.
            assign rnd_const = ACC_W'(1) << (sh - SH_W'(1));
            assign sum_rnd   = s2_sum_reg + rnd_const;
            assign shifted   = sum_rnd >>> sh;

            always_comb begin
                clamped = shifted[OUT_W-1:0];
                clip    = 1'b0;
                if (shifted > OUT_MAX) begin
                    clamped = {1'b0, {(OUT_W - 1){1'b1}}};
                    clip    = 1'b1;
                end else if (shifted < OUT_MIN) begin
                    clamped = {1'b1, {(OUT_W - 1){1'b0}}};
                    clip    = 1'b1;
                end
            end

            always_ff @(posedge adc_clk or negedge rst_n) begin
                if (!rst_n) begin
                    acc_reg    <= '0;
                    s2_sum_reg <= '0;
                    out_reg    <= '0;
                end else begin
                    if (frame_done) begin
                        acc_reg    <= '0;
                        s2_sum_reg <= frame_start ? sample : (acc_reg + sample);
                    end else if (frame_start) begin
                        acc_reg <= sample;
                    end else if (in_stb) begin
                        acc_reg <= acc_reg + sample;
                    end else if (restart) begin
                        acc_reg <= '0;
                    end

                    if (out_fire) begin
                        out_reg <= clamped;
                    end
                end
            end

            assign clip_vec[gi] = clip;
            assign out_val[gi]  = out_reg;
        end
    endgenerate

    assign out_stb = out_stb_reg;
    assign out_i   = out_val[0];
    assign out_q   = out_val[1];
    assign sat     = sat_reg;

endmodule

// File: tb/tb_wf_iq_boxcar_decim.sv
// -----------------------------------------------------------------------------
// tb_wf_iq_boxcar_decim
//
// Directed and randomized stimulus for wf_iq_boxcar_decim. A reference model
// keeps each frame as a queue of samples, averages it with real-valued
// arithmetic when the frame fills, and schedules the expected output one clock
// after completion; a negedge compare process checks every cycle.
// -----------------------------------------------------------------------------
module tb_wf_iq_boxcar_decim;

    localparam int IN_W     = 24;
    localparam int OUT_W    = 16;
    localparam int MAX_LOG2 = 7;

    logic             adc_clk    = 1'b0;
    logic             rst_n      = 1'b0;
    logic [2:0]       decim_log2 = 3'd0;
    logic             restart    = 1'b0;
    logic             in_stb     = 1'b0;
    logic [IN_W-1:0]  in_i       = '0;
    logic [IN_W-1:0]  in_q       = '0;
    logic             sat_clr    = 1'b0;
    logic             out_stb;
    logic [OUT_W-1:0] out_i;
    logic [OUT_W-1:0] out_q;
    logic             sat;

    int checks = 0;
    int errors = 0;

    always #5 adc_clk = ~adc_clk;

    wf_iq_boxcar_decim #(
        .IN_W     (IN_W),
        .OUT_W    (OUT_W),
        .MAX_LOG2 (MAX_LOG2)
    ) dut (
        .adc_clk    (adc_clk),
        .rst_n      (rst_n),
        .decim_log2 (decim_log2),
        .restart    (restart),
        .in_stb     (in_stb),
        .in_i       (in_i),
        .in_q       (in_q),
        .out_stb    (out_stb),
        .out_i      (out_i),
        .out_q      (out_q),
        .sat        (sat),
        .sat_clr    (sat_clr)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp_v, $time);
        end
    endtask

    // ------------------------------------------------------------------ model
    typedef struct {
        int          due;
        logic [15:0] vi;
        logic [15:0] vq;
        bit          clip;
    } res_t;

    res_t        pend[$];
    longint      fr_i[$];
    longint      fr_q[$];
    int          fr_k   = 0;
    int          cyc    = 0;
    bit          exp_stb = 1'b0;
    bit          exp_sat = 1'b0;
    logic [15:0] exp_i  = '0;
    logic [15:0] exp_q  = '0;
    bit          cmp_en = 1'b0;
    int          stb_seen = 0;

    function automatic longint sext(input logic [IN_W-1:0] x);
        return longint'(signed'(x));
    endfunction

    // Mean of the frame, scaled to OUT_W bits, rounded half up, then clamped.
    function automatic void avg_clip(input longint s[$], input int k,
                                     output logic [15:0] v, output bit clip);
        longint sum;
        longint r;
        real    div;
        sum = 0;
        foreach (s[n]) sum += s[n];
        div  = real'(longint'(1) << (k + IN_W - OUT_W));
        r    = longint'($floor(real'(sum) / div + 0.5));
        clip = 1'b0;
        if (r > 32767) begin
            r    = 32767;
            clip = 1'b1;
        end else if (r < -32768) begin
            r    = -32768;
            clip = 1'b1;
        end
        v = 16'(r);
    endfunction

    always @(posedge adc_clk) begin
        res_t r;
        bit   clip_now;
        bit   ci;
        bit   cq;
        exp_stb = 1'b0;
        if (!rst_n) begin
            pend.delete();
            fr_i.delete();
            fr_q.delete();
            exp_i   = '0;
            exp_q   = '0;
            exp_sat = 1'b0;
        end else begin
            cyc++;
            clip_now = 1'b0;
            if (pend.size() > 0 && pend[0].due == cyc) begin
                r = pend.pop_front();
                if (!restart) begin
                    exp_stb  = 1'b1;
                    exp_i    = r.vi;
                    exp_q    = r.vq;
                    clip_now = r.clip;
                end
            end
            if (clip_now) exp_sat = 1'b1;
            else if (sat_clr) exp_sat = 1'b0;

            if (restart) begin
                fr_i.delete();
                fr_q.delete();
            end
            if (in_stb) begin
                if (fr_i.size() == 0)
                    fr_k = (int'(decim_log2) > MAX_LOG2) ? MAX_LOG2 : int'(decim_log2);
                fr_i.push_back(sext(in_i));
                fr_q.push_back(sext(in_q));
                if (fr_i.size() == (1 << fr_k)) begin
                    avg_clip(fr_i, fr_k, r.vi, ci);
                    avg_clip(fr_q, fr_k, r.vq, cq);
                    r.clip = ci | cq;
                    r.due  = cyc + 1;
                    pend.push_back(r);
                    fr_i.delete();
                    fr_q.delete();
                end
            end
        end
    end

    // --------------------------------------------------------------- compare
    always @(negedge adc_clk) begin
        if (cmp_en) begin
            chk("out_stb", {31'd0, out_stb}, {31'd0, exp_stb});
            chk("out_i", {16'd0, out_i}, {16'd0, exp_i});
            chk("out_q", {16'd0, out_q}, {16'd0, exp_q});
            chk("sat", {31'd0, sat}, {31'd0, exp_sat});
            if (out_stb) begin
                stb_seen++;
                $display("txn %0d: out_i=%0d out_q=%0d sat=%0b", stb_seen,
                         $signed(out_i), $signed(out_q), sat);
            end
        end
    end

    initial begin
        #20ms;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    // ---------------------------------------------------------------- driver
    task automatic tick();
        @(negedge adc_clk);
    endtask

    task automatic idle(input int n);
        in_stb  = 1'b0;
        restart = 1'b0;
        sat_clr = 1'b0;
        repeat (n) tick();
    endtask

    task automatic push(input logic [IN_W-1:0] vi, input logic [IN_W-1:0] vq);
        in_stb = 1'b1;
        in_i   = vi;
        in_q   = vq;
        tick();
        in_stb  = 1'b0;
        restart = 1'b0;
    endtask

    initial begin
        int base;
        repeat (3) tick();
        chk("rst_stb", {31'd0, out_stb}, 32'd0);
        chk("rst_i", {16'd0, out_i}, 32'd0);
        chk("rst_q", {16'd0, out_q}, 32'd0);
        chk("rst_sat", {31'd0, sat}, 32'd0);
        rst_n  = 1'b1;
        cmp_en = 1'b1;
        idle(2);

        // 1: k=0, small values, 2-clock latency
        decim_log2 = 3'd0;
        push(24'h000080, 24'hFFFF80);
        chk("t1_early", {31'd0, out_stb}, 32'd0);
        tick();
        chk("t1_stb", {31'd0, out_stb}, 32'd1);
        chk("t1_i", {16'd0, out_i}, 32'd1);
        chk("t1_q", {16'd0, out_q}, 32'd0);
        chk("t1_sat", {31'd0, sat}, 32'd0);
        chk("t1_model_i", {16'd0, exp_i}, 32'd1);
        idle(2);

        // 2: k=0, full scale -> saturation, then sat_clr
        push(24'h7FFFFF, 24'h800000);
        tick();
        chk("t2_i", {16'd0, out_i}, 32'h7FFF);
        chk("t2_q", {16'd0, out_q}, 32'h8000);
        chk("t2_sat", {31'd0, sat}, 32'd1);
        chk("t2_model_q", {16'd0, exp_q}, 32'h8000);
        sat_clr = 1'b1;
        tick();
        sat_clr = 1'b0;
        chk("t2_satclr", {31'd0, sat}, 32'd0);
        idle(2);

        // 3: k=2, 256..1024 back to back -> (2560+512)>>10 = 3
        decim_log2 = 3'd2;
        base = stb_seen;
        for (int n = 1; n <= 4; n++) push(IN_W'(256 * n), 24'd0);
        idle(4);
        chk("t3_count", 32'(stb_seen - base), 32'd1);
        chk("t3_i", {16'd0, out_i}, 32'd3);
        chk("t3_q", {16'd0, out_q}, 32'd0);

        // 4: k=7, 128 x -256 every 3rd clock, decim_log2 changed mid-frame
        decim_log2 = 3'd7;
        base = stb_seen;
        for (int n = 0; n < 128; n++) begin
            if (n == 50) decim_log2 = 3'd0;
            push(-24'sd256, -24'sd256);
            idle(2);
        end
        idle(3);
        chk("t4_count", 32'(stb_seen - base), 32'd1);
        chk("t4_i", {16'd0, out_i}, 32'hFFFF);
        chk("t4_sat", {31'd0, sat}, 32'd0);

        // 5: k=3, restart coincident with the 6th sample
        decim_log2 = 3'd3;
        base = stb_seen;
        for (int n = 0; n < 5; n++) push(IN_W'($urandom), IN_W'($urandom));
        restart = 1'b1;
        push(IN_W'($urandom), IN_W'($urandom));
        for (int n = 0; n < 6; n++) push(IN_W'($urandom), IN_W'($urandom));
        idle(3);
        chk("t5_none_yet", 32'(stb_seen - base), 32'd0);
        push(IN_W'($urandom), IN_W'($urandom));
        idle(3);
        chk("t5_count", 32'(stb_seen - base), 32'd1);

        // 5b: restart drops a finished-but-undelivered result
        decim_log2 = 3'd0;
        base = stb_seen;
        push(24'h001000, 24'h002000);
        restart = 1'b1;
        tick();
        restart = 1'b0;
        idle(3);
        chk("t5b_suppressed", 32'(stb_seen - base), 32'd0);

        // 6: continuous k=0 stream of 1000 random samples
        base = stb_seen;
        for (int n = 0; n < 1000; n++) begin
            sat_clr = ($urandom_range(0, 19) == 0);
            in_stb  = 1'b1;
            in_i    = IN_W'($urandom);
            in_q    = IN_W'($urandom);
            tick();
        end
        idle(4);
        chk("t6_count", 32'(stb_seen - base), 32'd1000);

        // 6b: async reset mid-stream zeros the outputs at once
        for (int n = 0; n < 60; n++) begin
            in_stb = 1'b1;
            in_i   = (n == 57) ? 24'h7FFFFF : IN_W'($urandom);
            in_q   = IN_W'($urandom);
            tick();
        end
        #2 rst_n = 1'b0;
        #1;
        chk("t6b_rst_stb", {31'd0, out_stb}, 32'd0);
        chk("t6b_rst_i", {16'd0, out_i}, 32'd0);
        chk("t6b_rst_q", {16'd0, out_q}, 32'd0);
        chk("t6b_rst_sat", {31'd0, sat}, 32'd0);
        in_stb = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        idle(2);

        // 7: mixed random traffic (decim, duty, restart, sat_clr)
        for (int n = 0; n < 4000; n++) begin
            decim_log2 = 3'($urandom_range(0, 7));
            in_stb     = ($urandom_range(0, 9) < 7);
            restart    = ($urandom_range(0, 199) == 0);
            sat_clr    = ($urandom_range(0, 49) == 0);
            in_i       = IN_W'($urandom);
            in_q       = IN_W'($urandom);
            tick();
        end
        idle(5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
